// File: rtl/io_window_decoder.sv
// io_window_decoder: CPU I/O address decoder with double-buffered base/mask windows, wait-state stretching and timeout abort.
// Ports: cfg_clk/rst_n (async, active-high) clock and reset; addr/iorq_n/r_w_ CPU I/O cycle;
// dev_ready_n per-slot busy (0 = busy); cfg_we/cfg_addr/cfg_wdata/cfg_rdata byte config port;
// cs_n/ready_n/data_oe_n/data_dir/ff_oe_n cycle controls; win_valid/win_index/sel_slot latched decode; bus_err timeout pulse.
module io_window_decoder #(
    parameter int ADDR_W    = 32,
    parameter int NUM_WIN   = 16,
    parameter int NUM_SLOTS = 5,
    parameter int CFG_AW    = 8,
    parameter int WAIT_MAX  = 15
) (
    input  logic                         cfg_clk,
    input  logic                         rst_n,
    input  logic [ADDR_W-1:0]            addr,
    input  logic                         iorq_n,
    input  logic                         r_w_,
    input  logic [NUM_SLOTS-1:0]         dev_ready_n,
    input  logic                         cfg_we,
    input  logic [CFG_AW-1:0]            cfg_addr,
    input  logic [7:0]                   cfg_wdata,
    output logic [7:0]                   cfg_rdata,
    output logic [NUM_SLOTS-1:0]         cs_n,
    output logic                         ready_n,
    output logic                         data_oe_n,
    output logic                         data_dir,
    output logic                         ff_oe_n,
    output logic                         win_valid,
    output logic [$clog2(NUM_WIN)-1:0]   win_index,
    output logic [$clog2(NUM_SLOTS)-1:0] sel_slot,
    output logic                         bus_err
);
    localparam int CB       = (ADDR_W + 7) / 8;
    localparam int MASK_OFF = NUM_WIN * CB;
    localparam int SLOT_OFF = 2 * NUM_WIN * CB;
    localparam int OP_OFF   = SLOT_OFF + NUM_WIN;
    localparam int CTRL_OFF = OP_OFF + NUM_WIN;
    localparam int STAT_OFF = CTRL_OFF + 1;
    localparam int WI_W     = $clog2(NUM_WIN);
    localparam int SS_W     = $clog2(NUM_SLOTS);

    typedef enum logic [2:0] {IDLE, DECODE, ACTIVE, UNMAPPED, TIMEOUT} state_t;

    logic [CB*8-1:0] base_s [NUM_WIN];
    logic [CB*8-1:0] mask_s [NUM_WIN];
    logic [CB*8-1:0] base_a [NUM_WIN];
    logic [CB*8-1:0] mask_a [NUM_WIN];
    logic [7:0]      slot_s [NUM_WIN];
    logic [7:0]      op_s   [NUM_WIN];
    logic [7:0]      slot_a [NUM_WIN];
    logic [7:0]      op_a   [NUM_WIN];
    logic            commit_pending, to_sticky, commit_now;
    state_t          state, state_d;
    logic [7:0]      wait_cnt, wait_cnt_d;
    logic            hit, hit_q, rw_q, busy, to_enter, abort;
    logic [WI_W-1:0] hit_idx;
    logic [SS_W-1:0] hit_slot;
    logic [7:0]      rd_byte;

    // Active bank is only swapped between cycles so a decode never sees a half-updated map.
    assign commit_now = commit_pending && state == IDLE && iorq_n;
    assign busy       = !dev_ready_n[sel_slot];
    assign to_enter   = state == ACTIVE && state_d == TIMEOUT;
    assign abort      = state_d == UNMAPPED || state_d == TIMEOUT;

    always_ff @(posedge cfg_clk or posedge rst_n) begin
        if (rst_n) begin
            for (int w = 0; w < NUM_WIN; w++) begin
                base_s[w] <= '0;
                mask_s[w] <= '0;
                slot_s[w] <= '0;
                op_s[w]   <= 8'hFE;
                base_a[w] <= '0;
                mask_a[w] <= '0;
                slot_a[w] <= '0;
                op_a[w]   <= 8'hFE;
            end
            commit_pending <= 1'b0;
            to_sticky      <= 1'b0;
            cfg_rdata      <= '0;
        end else begin
            cfg_rdata <= rd_byte;
            if (commit_now) begin
                base_a         <= base_s;
                mask_a         <= mask_s;
                slot_a         <= slot_s;
                op_a           <= op_s;
                commit_pending <= 1'b0;
            end
            if (to_enter)
                to_sticky <= 1'b1;
            if (cfg_we) begin
                for (int w = 0; w < NUM_WIN; w++) begin
                    for (int b = 0; b < CB; b++) begin
                        if (cfg_addr == CFG_AW'(w * CB + b))
                            base_s[w][b*8 +: 8] <= cfg_wdata;
                        if (cfg_addr == CFG_AW'(MASK_OFF + w * CB + b))
                            mask_s[w][b*8 +: 8] <= cfg_wdata;
                    end
                    if (cfg_addr == CFG_AW'(SLOT_OFF + w))
                        slot_s[w] <= cfg_wdata;
                    if (cfg_addr == CFG_AW'(OP_OFF + w))
                        op_s[w] <= cfg_wdata;
                end
                if (cfg_addr == CFG_AW'(CTRL_OFF)) begin
                    if (cfg_wdata[0])
                        commit_pending <= 1'b1;
                    if (cfg_wdata[1])
                        to_sticky <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rd_byte = '0;
        for (int w = 0; w < NUM_WIN; w++) begin
            for (int b = 0; b < CB; b++) begin
                if (cfg_addr == CFG_AW'(w * CB + b))
                    rd_byte = base_s[w][b*8 +: 8];
                if (cfg_addr == CFG_AW'(MASK_OFF + w * CB + b))
                    rd_byte = mask_s[w][b*8 +: 8];
            end
            if (cfg_addr == CFG_AW'(SLOT_OFF + w))
                rd_byte = slot_s[w];
            if (cfg_addr == CFG_AW'(OP_OFF + w))
                rd_byte = op_s[w];
        end
        if (cfg_addr == CFG_AW'(STAT_OFF))
            rd_byte = {6'b0, to_sticky, commit_pending};
    end

    // Scan from the top so the lowest matching window is the last assignment and wins.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_slot = '0;
        for (int w = NUM_WIN - 1; w >= 0; w--) begin
            if ((((addr ^ base_a[w][ADDR_W-1:0]) & mask_a[w][ADDR_W-1:0]) == '0) &&
                (op_a[w] == 8'hFF || (op_a[w] == 8'h00 && !r_w_) || (op_a[w] == 8'h01 && r_w_)) &&
                slot_a[w] < 8'(NUM_SLOTS)) begin
                hit      = 1'b1;
                hit_idx  = WI_W'(w);
                hit_slot = slot_a[w][SS_W-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        if (iorq_n)
            state_d = IDLE;
        else if (state == IDLE)
            state_d = DECODE;
        else if (state == DECODE) begin
            state_d    = hit_q ? ACTIVE : UNMAPPED;
            wait_cnt_d = '0;
        end else if (state == ACTIVE) begin
            if (!busy)
                wait_cnt_d = '0;
            else if (9'(wait_cnt) + 9'd1 == 9'(WAIT_MAX))
                state_d = TIMEOUT;
            else
                wait_cnt_d = wait_cnt + 8'd1;
        end
    end

    // Cycle outputs are registered from the next state, so they are glitch-free and reset clears them at once.
    always_ff @(posedge cfg_clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            hit_q     <= 1'b0;
            rw_q      <= 1'b1;
            win_valid <= 1'b0;
            win_index <= '0;
            sel_slot  <= '0;
            cs_n      <= '1;
            ready_n   <= 1'b1;
            data_oe_n <= 1'b1;
            data_dir  <= 1'b1;
            ff_oe_n   <= 1'b1;
            bus_err   <= 1'b0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
            if (state == IDLE && !iorq_n) begin
                hit_q     <= hit;
                rw_q      <= r_w_;
                win_valid <= hit;
                win_index <= hit_idx;
                sel_slot  <= hit_slot;
            end
            cs_n      <= state_d == ACTIVE ? ~(NUM_SLOTS'(1) << sel_slot) : '1;
            data_oe_n <= state_d != ACTIVE;
            data_dir  <= state_d == ACTIVE ? rw_q : 1'b1;
            ff_oe_n   <= abort ? ~rw_q : 1'b1;
            ready_n   <= state_d == ACTIVE ? busy : !abort;
            bus_err   <= to_enter;
        end
    end
endmodule

// File: tb/tb_io_window_decoder.sv
// tb_io_window_decoder: directed vector bench for io_window_decoder.
module tb_io_window_decoder;
    logic        cfg_clk, rst_n, iorq_n, r_w_, cfg_we;
    logic [31:0] addr;
    logic [4:0]  dev_ready_n, cs_n;
    logic [7:0]  cfg_addr, cfg_wdata, cfg_rdata;
    logic        ready_n, data_oe_n, data_dir, ff_oe_n, win_valid, bus_err;
    logic [3:0]  win_index;
    logic [2:0]  sel_slot;
    int          total, bad;

    typedef struct {
        logic [31:0] a;
        logic        rw;
        logic [4:0]  cs;
        logic        oe, dir, ff, rdy, v;
        logic [3:0]  idx;
        logic [2:0]  sl;
    } vec_t;
    vec_t vt[9];

    io_window_decoder dut (
        .cfg_clk(cfg_clk), .rst_n(rst_n), .addr(addr), .iorq_n(iorq_n), .r_w_(r_w_),
        .dev_ready_n(dev_ready_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .cs_n(cs_n), .ready_n(ready_n), .data_oe_n(data_oe_n),
        .data_dir(data_dir), .ff_oe_n(ff_oe_n), .win_valid(win_valid), .win_index(win_index),
        .sel_slot(sel_slot), .bus_err(bus_err)
    );

    initial cfg_clk = 1'b0;
    always #5 cfg_clk = ~cfg_clk;

    task automatic tick;
        @(negedge cfg_clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg_wr(input int a, input logic [7:0] d);
        cfg_addr  = 8'(a);
        cfg_wdata = d;
        cfg_we    = 1'b1;
        tick;
        cfg_we    = 1'b0;
    endtask

    task automatic cfg_rd(input int a, output logic [7:0] d);
        cfg_addr = 8'(a);
        tick;
        d = cfg_rdata;
    endtask

    task automatic prog(input int w, input logic [31:0] b, input logic [31:0] m, input logic [7:0] s, input logic [7:0] op);
        for (int i = 0; i < 4; i++) begin
            cfg_wr(w * 4 + i, b[i*8 +: 8]);
            cfg_wr(64 + w * 4 + i, m[i*8 +: 8]);
        end
        cfg_wr(128 + w, s);
        cfg_wr(144 + w, op);
    endtask

    task automatic start(input logic [31:0] a, input logic rw);
        addr   = a;
        r_w_   = rw;
        iorq_n = 1'b0;
        tick;
        tick;
    endtask

    task automatic finish_cycle;
        iorq_n = 1'b1;
        tick;
    endtask

    initial begin
        logic [7:0] d;
        int n;
        logic berr;
        total = 0; bad = 0;
        rst_n = 1'b1; iorq_n = 1'b1; r_w_ = 1'b1; addr = '0; dev_ready_n = '1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        vt[0] = '{32'h10000004, 1'b0, 5'h1E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 3'd0};
        vt[1] = '{32'h100000FF, 1'b1, 5'h1E, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 3'd0};
        vt[2] = '{32'h10000200, 1'b0, 5'h1E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 3'd0};
        vt[3] = '{32'h10000210, 1'b1, 5'h1F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0};
        vt[4] = '{32'h30000010, 1'b0, 5'h1F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 3'd0};
        vt[5] = '{32'h50000004, 1'b1, 5'h17, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 3'd3};
        vt[6] = '{32'h50000004, 1'b0, 5'h1F, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 3'd0};
        vt[7] = '{32'h7FFFFFFF, 1'b1, 5'h1F, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0};
        vt[8] = '{32'h1000000C, 1'b0, 5'h1E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 3'd0};
        tick; tick;
        chk("rst_cs_n", cs_n, 5'h1F);
        chk("rst_ready_n", ready_n, 1);
        chk("rst_data_oe_n", data_oe_n, 1);
        chk("rst_data_dir", data_dir, 1);
        chk("rst_ff_oe_n", ff_oe_n, 1);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_win_index", win_index, 0);
        chk("rst_sel_slot", sel_slot, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_cfg_rdata", cfg_rdata, 0);
        rst_n = 1'b0;
        tick;
        cfg_rd(144, d); chk("rd_op0_default", d, 8'hFE);
        cfg_rd(161, d); chk("rd_status_reset", d, 8'h00);
        cfg_wr(200, 8'h55);
        cfg_rd(200, d); chk("rd_unused", d, 8'h00);

        prog(0, 32'h10000000, 32'hFFFFFF00, 8'd0, 8'hFF);
        prog(1, 32'h10000000, 32'hFFFFFFF0, 8'd2, 8'hFF);
        prog(2, 32'h10000200, 32'hFFFFFF00, 8'd0, 8'h00);
        prog(3, 32'h30000000, 32'hFFFFFF00, 8'd7, 8'hFF);
        prog(5, 32'h50000000, 32'hFFFF0000, 8'd3, 8'h01);
        cfg_rd(0, d);   chk("rd_base0_b0", d, 8'h00);
        cfg_rd(3, d);   chk("rd_base0_b3", d, 8'h10);
        cfg_rd(64, d);  chk("rd_mask0_b0", d, 8'h00);
        cfg_rd(67, d);  chk("rd_mask0_b3", d, 8'hFF);
        cfg_rd(130, d); chk("rd_slot2", d, 8'h00);
        cfg_rd(149, d); chk("rd_op5", d, 8'h01);

        start(32'h10000004, 1'b0);
        chk("precommit_cs_n", cs_n, 5'h1F);
        chk("precommit_ready_n", ready_n, 0);
        chk("precommit_data_oe_n", data_oe_n, 1);
        finish_cycle;

        cfg_wr(160, 8'h01);
        tick;
        cfg_rd(161, d); chk("status_after_commit", d, 8'h00);

        for (int i = 0; i < 9; i++) begin
            start(vt[i].a, vt[i].rw);
            chk($sformatf("v%0d_cs_n", i), cs_n, vt[i].cs);
            chk($sformatf("v%0d_data_oe_n", i), data_oe_n, vt[i].oe);
            chk($sformatf("v%0d_data_dir", i), data_dir, vt[i].dir);
            chk($sformatf("v%0d_ff_oe_n", i), ff_oe_n, vt[i].ff);
            chk($sformatf("v%0d_ready_n", i), ready_n, vt[i].rdy);
            chk($sformatf("v%0d_win_valid", i), win_valid, vt[i].v);
            chk($sformatf("v%0d_win_index", i), win_index, vt[i].idx);
            chk($sformatf("v%0d_sel_slot", i), sel_slot, vt[i].sl);
            finish_cycle;
        end
        chk("idle_cs_n", cs_n, 5'h1F);
        chk("idle_ready_n", ready_n, 1);
        chk("idle_data_oe_n", data_oe_n, 1);
        chk("idle_win_valid_held", win_valid, 1);

        prog(4, 32'h20000000, 32'hFFFFFF00, 8'd1, 8'hFF);
        cfg_rd(132, d); chk("rd_slot4_shadow", d, 8'h01);
        start(32'h20000000, 1'b0);
        chk("w4_shadow_cs_n", cs_n, 5'h1F);
        chk("w4_shadow_win_valid", win_valid, 0);
        cfg_rd(161, d); chk("w4_status_idle", d, 8'h00);
        cfg_wr(160, 8'h01);
        cfg_rd(161, d); chk("w4_status_pending", d, 8'h01);
        cfg_rd(161, d); chk("w4_status_still_pending", d, 8'h01);
        finish_cycle;
        tick;
        cfg_rd(161, d); chk("w4_status_committed", d, 8'h00);
        start(32'h20000000, 1'b0);
        chk("w4_cs_n", cs_n, 5'h1D);
        chk("w4_win_index", win_index, 4);
        chk("w4_sel_slot", sel_slot, 1);
        finish_cycle;

        dev_ready_n = 5'b11101;
        start(32'h20000000, 1'b1);
        n = 0; berr = 1'b0;
        for (int i = 0; i < 40 && ready_n; i++) begin
            n++;
            if (bus_err) berr = 1'b1;
            if (n == 5) dev_ready_n = '1;
            tick;
        end
        chk("busy_cycles", n, 5);
        chk("busy_no_bus_err", berr | bus_err, 0);
        chk("busy_cs_n", cs_n, 5'h1D);
        chk("busy_ready_n_end", ready_n, 0);
        finish_cycle;

        dev_ready_n = 5'b11101;
        start(32'h20000000, 1'b1);
        n = 0;
        for (int i = 0; i < 60 && !bus_err; i++) begin
            if (ready_n) n++;
            tick;
        end
        chk("to_busy_cycles", n, 15);
        chk("to_bus_err", bus_err, 1);
        chk("to_cs_n", cs_n, 5'h1F);
        chk("to_data_oe_n", data_oe_n, 1);
        chk("to_ff_oe_n", ff_oe_n, 0);
        chk("to_ready_n", ready_n, 0);
        tick;
        chk("to_bus_err_pulse", bus_err, 0);
        chk("to_ff_oe_n_hold", ff_oe_n, 0);
        finish_cycle;
        dev_ready_n = '1;
        cfg_rd(161, d); chk("to_status_sticky", d, 8'h02);
        cfg_wr(160, 8'h02);
        cfg_rd(161, d); chk("to_status_cleared", d, 8'h00);

        start(32'h20000000, 1'b0);
        chk("pre_rst_cs_n", cs_n, 5'h1D);
        #2 rst_n = 1'b1;
        #1;
        chk("async_rst_cs_n", cs_n, 5'h1F);
        chk("async_rst_data_oe_n", data_oe_n, 1);
        chk("async_rst_ready_n", ready_n, 1);
        iorq_n = 1'b1;
        tick;
        rst_n = 1'b0;
        cfg_rd(148, d); chk("post_rst_op4_shadow", d, 8'hFE);
        start(32'h20000000, 1'b1);
        chk("post_rst_cs_n", cs_n, 5'h1F);
        chk("post_rst_ff_oe_n", ff_oe_n, 0);
        chk("post_rst_win_valid", win_valid, 0);
        finish_cycle;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
